// File: rtl/sv_stream_ctrl.sv
// sv_stream_ctrl
// Sequencing controller for one SVM cascade stage. It loads a test image into
// the test-pixel buffer, then streams every support-vector pixel with the
// matching test-pixel address to the kernel unit under pix_ready flow control.
// It then drains the memory read pipeline, pulses decision_funct_en, and
// signals done.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               begin one classification (sampled in IDLE only)
//   in_valid, in_data   incoming test pixel stream (LOAD only)
//   pix_ready           kernel can accept another read issue
//   x_we/x_waddr/x_wdata   test-buffer write port
//   rd_en/sv_addr/px_addr  read issue to SV memory and test buffer
//   pix_valid, first_pix, last_pix, last_sv   read data qualifiers, RD_LAT after rd_en
//   stall_MEM           high during LOAD
//   decision_funct_en   one-cycle pulse to the decision-function stage
//   busy, done          activity flag and completion pulse
module sv_stream_ctrl #(
    parameter int XLEN_PIXEL    = 8,
    parameter int NUM_OF_PIXELS = 784,
    parameter int NUM_OF_SV     = 87,
    parameter int RD_LAT        = 1,
    parameter int PIX_AW        = $clog2(NUM_OF_PIXELS),
    parameter int SV_AW         = $clog2(NUM_OF_SV)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [XLEN_PIXEL-1:0] in_data,
    input  logic                  pix_ready,
    output logic                  x_we,
    output logic [PIX_AW-1:0]     x_waddr,
    output logic [XLEN_PIXEL-1:0] x_wdata,
    output logic                  rd_en,
    output logic [SV_AW-1:0]      sv_addr,
    output logic [PIX_AW-1:0]     px_addr,
    output logic                  pix_valid,
    output logic                  first_pix,
    output logic                  last_pix,
    output logic                  last_sv,
    output logic                  stall_MEM,
    output logic                  decision_funct_en,
    output logic                  busy,
    output logic                  done
);

    localparam int DW = $clog2(RD_LAT + 1);
    localparam logic [PIX_AW-1:0] PIX_LAST = PIX_AW'(NUM_OF_PIXELS - 1);
    localparam logic [SV_AW-1:0]  SV_LAST  = SV_AW'(NUM_OF_SV - 1);
    localparam logic [DW-1:0]     DRN_LAST = DW'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_DECIDE = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    typedef struct packed {
        logic valid;
        logic first;
        logic last_pix;
        logic last_sv;
    } beat_t;

    state_t            state_q, state_d;
    logic [PIX_AW-1:0] pix_q, pix_d;
    logic [SV_AW-1:0]  sv_q, sv_d;
    logic [DW-1:0]     drn_q, drn_d;
    beat_t             pipe_q [RD_LAT];
    beat_t             beat_s;
    logic              issue_s;

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pix_q   <= '0;
            sv_q    <= '0;
            drn_q   <= '0;
        end else begin
            state_q <= state_d;
            pix_q   <= pix_d;
            sv_q    <= sv_d;
            drn_q   <= drn_d;
        end
    end

    // Next-state and counter update logic.
    always_comb begin
        state_d = state_q;
        pix_d   = pix_q;
        sv_d    = sv_q;
        drn_d   = drn_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    pix_d   = '0;
                    sv_d    = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    if (pix_q == PIX_LAST) begin
                        pix_d   = '0;
                        state_d = S_STREAM;
                    end else begin
                        pix_d = pix_q + PIX_AW'(1);
                    end
                end else begin
                    pix_d = pix_q;
                end
            end
            S_STREAM: begin
                if (pix_ready) begin
                    if (pix_q == PIX_LAST) begin
                        pix_d = '0;
                        if (sv_q == SV_LAST) begin
                            // Final issue: counters return to zero so no
                            // address beyond the terminal values is ever held.
                            sv_d    = '0;
                            drn_d   = '0;
                            state_d = S_DRAIN;
                        end else begin
                            sv_d = sv_q + SV_AW'(1);
                        end
                    end else begin
                        pix_d = pix_q + PIX_AW'(1);
                    end
                end else begin
                    pix_d = pix_q;
                end
            end
            S_DRAIN: begin
                // Wait out the read latency so every in-flight beat emerges.
                if (drn_q == DRN_LAST) begin
                    drn_d   = '0;
                    state_d = S_DECIDE;
                end else begin
                    drn_d = drn_q + DW'(1);
                end
            end
            S_DECIDE: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output decode from the registered state and counters.
    always_comb begin
        x_we              = 1'b0;
        x_waddr           = '0;
        x_wdata           = '0;
        rd_en             = 1'b0;
        sv_addr           = '0;
        px_addr           = '0;
        stall_MEM         = 1'b0;
        decision_funct_en = 1'b0;
        done              = 1'b0;
        busy              = (state_q != S_IDLE);
        case (state_q)
            S_LOAD: begin
                stall_MEM = 1'b1;
                x_we      = in_valid;
                x_waddr   = pix_q;
                x_wdata   = in_data;
            end
            S_STREAM: begin
                rd_en   = pix_ready;
                sv_addr = sv_q;
                px_addr = pix_q;
            end
            S_DECIDE: decision_funct_en = 1'b1;
            S_DONE:   done = 1'b1;
            default: begin
                busy = (state_q != S_IDLE);
            end
        endcase
    end

    // Beat descriptor entering the read-latency pipeline.
    always_comb begin
        issue_s         = (state_q == S_STREAM) && pix_ready;
        beat_s.valid    = issue_s;
        beat_s.first    = issue_s && (pix_q == '0);
        beat_s.last_pix = issue_s && (pix_q == PIX_LAST);
        beat_s.last_sv  = issue_s && (sv_q == SV_LAST);
    end

    // Read-latency pipeline aligning qualifiers with memory data.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= beat_s;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign pix_valid = pipe_q[RD_LAT-1].valid;
    assign first_pix = pipe_q[RD_LAT-1].first;
    assign last_pix  = pipe_q[RD_LAT-1].last_pix;
    assign last_sv   = pipe_q[RD_LAT-1].last_sv;

endmodule

// File: tb/tb_sv_stream_ctrl.sv
module tb_sv_stream_ctrl;

    localparam int P    = 4;
    localparam int S    = 3;
    localparam int R    = 2;
    localparam int MAXC = 256;

    logic       clk = 1'b0;
    logic       rst, start, in_valid, pix_ready;
    logic [7:0] in_data;

    logic       x_we, rd_en, pix_valid, first_pix, last_pix, last_sv;
    logic       stall_MEM, decision_funct_en, busy, done;
    logic [1:0] x_waddr, sv_addr, px_addr;
    logic [7:0] x_wdata;

    // sweep instances: 0 -> RD_LAT=1, 1 -> RD_LAT=3, 2 -> NUM_OF_SV=1
    logic       sw_we [3], sw_rd [3], sw_pv [3], sw_fp [3], sw_lp [3], sw_ls [3];
    logic       sw_st [3], sw_dec [3], sw_busy [3], sw_done [3];
    logic [1:0] sw_wa [3], sw_px [3];
    logic [7:0] sw_wd [3];
    logic [1:0] sw_sv01 [2];
    logic [0:0] sw_sv2;

    int checks   = 0;
    int failures = 0;

    logic       iv_a  [MAXC];
    logic       pr_a  [MAXC];
    logic [7:0] dat_a [MAXC];
    bit         junk;
    int         obs_dec, obs_done;

    // expected per cycle: {stall,we,rd,pv,fp,lp,ls,dec,done,busy}
    logic [9:0] e_ctl [MAXC];
    bit         e_str [MAXC];
    int         e_wa [MAXC], e_wd [MAXC], e_sv [MAXC], e_px [MAXC];

    always #5 clk = ~clk;

    sv_stream_ctrl #(.XLEN_PIXEL(8), .NUM_OF_PIXELS(P), .NUM_OF_SV(S), .RD_LAT(R)) u_dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .pix_ready(pix_ready), .x_we(x_we), .x_waddr(x_waddr), .x_wdata(x_wdata),
        .rd_en(rd_en), .sv_addr(sv_addr), .px_addr(px_addr), .pix_valid(pix_valid),
        .first_pix(first_pix), .last_pix(last_pix), .last_sv(last_sv),
        .stall_MEM(stall_MEM), .decision_funct_en(decision_funct_en), .busy(busy), .done(done)
    );

    sv_stream_ctrl #(.XLEN_PIXEL(8), .NUM_OF_PIXELS(P), .NUM_OF_SV(3), .RD_LAT(1)) u_r1 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .pix_ready(pix_ready), .x_we(sw_we[0]), .x_waddr(sw_wa[0]), .x_wdata(sw_wd[0]),
        .rd_en(sw_rd[0]), .sv_addr(sw_sv01[0]), .px_addr(sw_px[0]), .pix_valid(sw_pv[0]),
        .first_pix(sw_fp[0]), .last_pix(sw_lp[0]), .last_sv(sw_ls[0]),
        .stall_MEM(sw_st[0]), .decision_funct_en(sw_dec[0]), .busy(sw_busy[0]), .done(sw_done[0])
    );

    sv_stream_ctrl #(.XLEN_PIXEL(8), .NUM_OF_PIXELS(P), .NUM_OF_SV(3), .RD_LAT(3)) u_r3 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .pix_ready(pix_ready), .x_we(sw_we[1]), .x_waddr(sw_wa[1]), .x_wdata(sw_wd[1]),
        .rd_en(sw_rd[1]), .sv_addr(sw_sv01[1]), .px_addr(sw_px[1]), .pix_valid(sw_pv[1]),
        .first_pix(sw_fp[1]), .last_pix(sw_lp[1]), .last_sv(sw_ls[1]),
        .stall_MEM(sw_st[1]), .decision_funct_en(sw_dec[1]), .busy(sw_busy[1]), .done(sw_done[1])
    );

    sv_stream_ctrl #(.XLEN_PIXEL(8), .NUM_OF_PIXELS(P), .NUM_OF_SV(1), .RD_LAT(2), .SV_AW(1)) u_s1 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .pix_ready(pix_ready), .x_we(sw_we[2]), .x_waddr(sw_wa[2]), .x_wdata(sw_wd[2]),
        .rd_en(sw_rd[2]), .sv_addr(sw_sv2), .px_addr(sw_px[2]), .pix_valid(sw_pv[2]),
        .first_pix(sw_fp[2]), .last_pix(sw_lp[2]), .last_sv(sw_ls[2]),
        .stall_MEM(sw_st[2]), .decision_funct_en(sw_dec[2]), .busy(sw_busy[2]), .done(sw_done[2])
    );

    task automatic fill_stim(input int iv_rate, input int pr_rate);
        for (int c = 0; c < MAXC; c++) begin
            iv_a[c]  = ($urandom_range(0, 99) < iv_rate);
            pr_a[c]  = ($urandom_range(0, 99) < pr_rate);
            dat_a[c] = 8'($urandom);
        end
    endtask

    // Model walks the stimulus: P accepted writes, then P*S accepted issues,
    // then RD_LAT drain cycles, decide, done. Then the DUT is driven and checked.
    task automatic run_op(input string name);
        int         cnt, k, c, dcy;
        logic [9:0] got;
        for (int i = 0; i < MAXC; i++) begin
            e_ctl[i] = '0; e_str[i] = 1'b0;
            e_wa[i] = 0; e_wd[i] = 0; e_sv[i] = 0; e_px[i] = 0;
        end
        cnt = 0;
        c   = 1;
        while (cnt < P && c < MAXC - 16) begin
            e_ctl[c][9] = 1'b1;
            if (iv_a[c]) begin
                e_ctl[c][8] = 1'b1; e_wa[c] = cnt; e_wd[c] = int'(dat_a[c]); cnt++;
            end
            c++;
        end
        k = 0;
        while (k < P * S && c < MAXC - 16) begin
            e_str[c] = 1'b1; e_sv[c] = k / P; e_px[c] = k % P;
            if (pr_a[c]) begin
                e_ctl[c][7]     = 1'b1;
                e_ctl[c + R][6] = 1'b1;
                e_ctl[c + R][5] = (k % P == 0);
                e_ctl[c + R][4] = (k % P == P - 1);
                e_ctl[c + R][3] = (k / P == S - 1);
                k++;
            end
            c++;
        end
        if (cnt < P || k < P * S) begin
            checks++; failures++;
            $display("FAIL %s stimulus: got %0d writes %0d issues, required %0d and %0d", name, cnt, k, P, P * S);
            return;
        end
        dcy = c + R;
        e_ctl[dcy][2]     = 1'b1;
        e_ctl[dcy + 1][1] = 1'b1;
        for (int i = 1; i <= dcy + 1; i++) e_ctl[i][0] = 1'b1;

        @(posedge clk); #1;
        start = 1'b1; in_valid = 1'b0; pix_ready = 1'b0;
        obs_dec = -1; obs_done = -1;
        for (int cy = 1; cy <= dcy + 2; cy++) begin
            @(posedge clk); #1;
            start     = (junk && cy <= dcy + 1) ? 1'b1 : 1'b0;
            in_valid  = iv_a[cy];
            in_data   = dat_a[cy];
            pix_ready = pr_a[cy];
            #1;
            got = {stall_MEM, x_we, rd_en, pix_valid, first_pix, last_pix, last_sv,
                   decision_funct_en, done, busy};
            if (decision_funct_en === 1'b1) obs_dec = cy;
            if (done === 1'b1) obs_done = cy;
            checks++;
            if (got !== e_ctl[cy]) begin
                failures++;
                $display("FAIL %s ctl cycle %0d: got %b required %b", name, cy, got, e_ctl[cy]);
            end
            if (e_ctl[cy][8]) begin
                checks++;
                if ({x_waddr, x_wdata} !== {2'(e_wa[cy]), 8'(e_wd[cy])}) begin
                    failures++;
                    $display("FAIL %s write cycle %0d: got addr %0d data %0d required %0d %0d",
                             name, cy, x_waddr, x_wdata, e_wa[cy], e_wd[cy]);
                end
            end
            if (e_str[cy]) begin
                checks++;
                if ({sv_addr, px_addr} !== {2'(e_sv[cy]), 2'(e_px[cy])}) begin
                    failures++;
                    $display("FAIL %s addr cycle %0d: got sv %0d px %0d required %0d %0d",
                             name, cy, sv_addr, px_addr, e_sv[cy], e_px[cy]);
                end
            end
        end
        start = 1'b0; in_valid = 1'b0; pix_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; in_valid = 1'b1; in_data = 8'd0; pix_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({x_we, x_waddr, x_wdata, rd_en, sv_addr, px_addr, pix_valid, first_pix, last_pix,
             last_sv, stall_MEM, decision_funct_en, busy, done} !== 24'd0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b we=%b rd=%b pv=%b required all 0", busy, x_we, rd_en, pix_valid);
        end
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; pix_ready = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_start_ignored: got busy %b required 0", busy);
        end
    endtask

    task automatic test_nominal();
        for (int c = 0; c < MAXC; c++) begin
            iv_a[c] = (c >= 1 && c <= 4); pr_a[c] = 1'b1; dat_a[c] = 8'(9 + c);
        end
        junk = 1'b0;
        run_op("nominal");
        checks++;
        if (obs_dec !== 19) begin failures++; $display("FAIL nominal_decide: got %0d required 19", obs_dec); end
        checks++;
        if (obs_done !== 20) begin failures++; $display("FAIL nominal_done: got %0d required 20", obs_done); end
    endtask

    task automatic test_flow_control();
        for (int c = 0; c < MAXC; c++) begin
            iv_a[c] = !(c == 2 || c == 3); pr_a[c] = !(c == 10 || c == 12); dat_a[c] = 8'($urandom);
        end
        junk = 1'b0;
        run_op("flow");
        checks++;
        if (obs_done !== 24) begin failures++; $display("FAIL flow_done: got %0d required 24", obs_done); end
    endtask

    task automatic test_random();
        junk = 1'b0;
        for (int n = 0; n < 4; n++) begin
            fill_stim(65, 60);
            run_op("random");
        end
    endtask

    task automatic test_ignored_inputs();
        fill_stim(100, 100);
        junk = 1'b1;
        run_op("ignored");
        junk = 1'b0;
    endtask

    task automatic test_mid_reset();
        @(posedge clk); #1;
        start = 1'b1; in_valid = 1'b0; pix_ready = 1'b0;
        for (int cy = 1; cy <= 11; cy++) begin
            @(posedge clk); #1;
            start = 1'b0; in_valid = 1'b1; in_data = 8'($urandom); pix_ready = 1'b1;
            #1;
        end
        checks++;
        if ({rd_en, sv_addr, px_addr} !== {1'b1, 2'd1, 2'd2}) begin
            failures++;
            $display("FAIL midrst_pre: got rd %b sv %0d px %0d required 1 1 2", rd_en, sv_addr, px_addr);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; pix_ready = 1'b0;
        #1;
        checks++;
        if ({busy, rd_en, pix_valid} !== 3'b000) begin
            failures++;
            $display("FAIL midrst_idle: got busy %b rd %b pv %b required 000", busy, rd_en, pix_valid);
        end
        for (int cy = 0; cy < 4; cy++) begin
            @(posedge clk); #2;
            checks++;
            if ({busy, pix_valid} !== 2'b00) begin
                failures++;
                $display("FAIL midrst_flush: got busy %b pv %b required 00", busy, pix_valid);
            end
        end
        fill_stim(100, 100);
        junk = 1'b0;
        run_op("post_reset");
    endtask

    task automatic test_sweep();
        int rl [3] = '{1, 3, 2};
        int sl [3] = '{3, 3, 1};
        int f_rd [3], l_rd [3], n_pv [3], f_pv [3], l_pv [3], n_ls [3], c_dec [3], c_done [3];
        for (int k = 0; k < 3; k++) begin
            f_rd[k] = -1; l_rd[k] = -1; n_pv[k] = 0; f_pv[k] = -1; l_pv[k] = -1;
            n_ls[k] = 0; c_dec[k] = -1; c_done[k] = -1;
        end
        rst = 1'b1; start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b1;
        for (int cy = 1; cy <= 32; cy++) begin
            @(posedge clk); #1;
            start = 1'b0; in_valid = 1'b1; pix_ready = 1'b1; in_data = 8'($urandom);
            #1;
            for (int k = 0; k < 3; k++) begin
                if (sw_rd[k] === 1'b1) begin
                    if (f_rd[k] < 0) f_rd[k] = cy;
                    l_rd[k] = cy;
                end
                if (sw_pv[k] === 1'b1) begin
                    n_pv[k]++;
                    if (f_pv[k] < 0) f_pv[k] = cy;
                    l_pv[k] = cy;
                    if (sw_ls[k] === 1'b1) n_ls[k]++;
                end
                if (sw_dec[k] === 1'b1) c_dec[k] = cy;
                if (sw_done[k] === 1'b1) c_done[k] = cy;
            end
        end
        in_valid = 1'b0; pix_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (f_rd[k] != P + 1 || l_rd[k] != P + P * sl[k]) begin
                failures++;
                $display("FAIL sweep%0d_issue: got %0d..%0d required %0d..%0d", k, f_rd[k], l_rd[k], P + 1, P + P * sl[k]);
            end
            checks++;
            if (n_pv[k] != P * sl[k] || f_pv[k] != P + 1 + rl[k] || l_pv[k] != P + P * sl[k] + rl[k]) begin
                failures++;
                $display("FAIL sweep%0d_beats: got n=%0d %0d..%0d required n=%0d %0d..%0d", k, n_pv[k], f_pv[k],
                         l_pv[k], P * sl[k], P + 1 + rl[k], P + P * sl[k] + rl[k]);
            end
            checks++;
            if (n_ls[k] != P) begin
                failures++;
                $display("FAIL sweep%0d_last_sv: got %0d required %0d", k, n_ls[k], P);
            end
            checks++;
            if (c_dec[k] != P + P * sl[k] + rl[k] + 1 || c_done[k] != P + P * sl[k] + rl[k] + 2) begin
                failures++;
                $display("FAIL sweep%0d_timing: got dec %0d done %0d required %0d %0d", k, c_dec[k], c_done[k],
                         P + P * sl[k] + rl[k] + 1, P + P * sl[k] + rl[k] + 2);
            end
            checks++;
            if (c_dec[k] - l_rd[k] - 1 != rl[k] || l_pv[k] != c_dec[k] - 1) begin
                failures++;
                $display("FAIL sweep%0d_drain: got %0d cycles required %0d", k, c_dec[k] - l_rd[k] - 1, rl[k]);
            end
        end
    endtask

    initial begin
        junk = 1'b0;
        test_reset();
        test_nominal();
        test_flow_control();
        test_random();
        test_ignored_inputs();
        test_mid_reset();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
